// File: rtl/seg7_scan_capture.sv
// Captures the digits shown on a scanned, active-low 4-digit 7-segment display.
// Inputs are synchronized and debounced; a stable frame is decoded into digits/valid.

module seg7_scan_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       ok,
  input  logic [3:0] val,
  output logic [3:0] digit,
  output logic       vld
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'h0;
      vld   <= 1'b0;
    end else if (wr) begin
      vld <= ok;
      // An undecodable pattern keeps the last good digit.
      if (ok) digit <= val;
    end
  end
endmodule

module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodo,
  input  logic [6:0]  catodo,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        frame_strobe,
  output logic        seg_err,
  output logic        anode_err
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_t;

  localparam scan_t SCAN_OFF = '{an: 4'hF, seg: 7'h7F};

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  scan_t [SYNC_STAGES-1:0]   sync_q;
  scan_t                     sample;
  scan_t                     prev_q;
  logic  [1:0]               rst_pipe;
  logic                      armed;
  logic                      changed;
  logic  [7:0]               cnt_q;
  state_t                    state_q, state_d;
  logic                      capture;
  logic  [NUM_LANES-1:0]     sel;
  logic                      one_hot, multi;
  logic                      dec_ok;
  logic  [3:0]               dec_val;
  logic  [NUM_LANES-1:0]     lane_wr;
  logic  [NUM_LANES-1:0]     seen_q;
  logic  [NUM_LANES-1:0][3:0] digit_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{SCAN_OFF}};
    end else begin
      sync_q[0] <= '{an: anodo, seg: catodo};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // Reset release is resynchronized; the FSM stays in IDLE until armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign armed   = rst_pipe[1];
  assign changed = (sample != prev_q);

  // prev is pinned to "all off" until armed so a change seen during release is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= SCAN_OFF;
      cnt_q  <= 8'd0;
    end else if (!armed) begin
      prev_q <= SCAN_OFF;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= sample;
      if (changed)             cnt_q <= 8'd0;
      else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // cnt counts identical samples after the first, so STABLE_CYCLES samples means cnt == STABLE_CYCLES-2.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:     if (armed && changed) state_d = SETTLE;
      SETTLE: begin
        if (!changed && cnt_q == 8'(STABLE_CYCLES - 2)) begin
          state_d = CAPTURED;
          capture = 1'b1;
        end
      end
      CAPTURED: if (changed) state_d = SETTLE;
      default:  state_d = IDLE;
    endcase
  end

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = {1'b1, 4'h0};
      7'h79: seg_decode = {1'b1, 4'h1};
      7'h24: seg_decode = {1'b1, 4'h2};
      7'h30: seg_decode = {1'b1, 4'h3};
      7'h19: seg_decode = {1'b1, 4'h4};
      7'h12: seg_decode = {1'b1, 4'h5};
      7'h02: seg_decode = {1'b1, 4'h6};
      7'h78: seg_decode = {1'b1, 4'h7};
      7'h00: seg_decode = {1'b1, 4'h8};
      7'h10: seg_decode = {1'b1, 4'h9};
      7'h08: seg_decode = {1'b1, 4'hA};
      7'h03: seg_decode = {1'b1, 4'hB};
      7'h46: seg_decode = {1'b1, 4'hC};
      7'h21: seg_decode = {1'b1, 4'hD};
      7'h06: seg_decode = {1'b1, 4'hE};
      7'h0E: seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'h00;
    endcase
  endfunction

  assign {dec_ok, dec_val} = seg_decode(sample.seg);
  assign sel     = ~sample.an;
  assign one_hot = (sel != '0) && ((sel & (sel - 4'd1)) == '0);
  assign multi   = (sel != '0) && !one_hot;
  assign lane_wr = (capture && one_hot) ? sel : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    seg7_scan_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (lane_wr[i]),
      .ok    (dec_ok),
      .val   (dec_val),
      .digit (digit_w[i]),
      .vld   (valid[i])
    );
  end

  assign digits = digit_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_err   <= 1'b0;
      anode_err <= 1'b0;
    end else begin
      seg_err   <= capture && one_hot && !dec_ok;
      anode_err <= capture && multi;
    end
  end

  // A full mask fires the strobe next cycle; a capture landing on that cycle starts the new mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q       <= '0;
      frame_strobe <= 1'b0;
    end else if (seen_q == '1) begin
      seen_q       <= lane_wr;
      frame_strobe <= 1'b1;
    end else begin
      seen_q       <= seen_q | lane_wr;
      frame_strobe <= 1'b0;
    end
  end
endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 16, meaning consecutive identical synchronized samples required before capture (legal range 2..255).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, meaning input synchronizer depth (legal range 2..3).
REQ-003 SHALL have port clk  input  1  single system clock, 100 MHz, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port anodo  input  4  digit enables, active-low; bit i low selects display position i.
REQ-006 SHALL have port catodo  input  7  segment lines, active-low; bit0=a ... bit6=g.
REQ-007 SHALL have port digits  output  16  captured values; digits[4i+3:4i] holds position i.
REQ-008 SHALL have port valid  output  4  bit i high when digits for position i holds a legally decoded value.
REQ-009 SHALL have port frame_strobe  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-010 SHALL have port seg_err  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-011 SHALL have port anode_err  output  1  one-cycle pulse on capture with more than one anodo bit low.

Function
REQ-012 SHALL pass anodo and catodo through SYNC_STAGES flops; all decisions use the last stage ("sample").
REQ-013 SHALL hold a register of the previous sample and a saturating stability counter; counter clears on any sample change and increments otherwise.
REQ-014 SHALL implement FSM states IDLE, SETTLE, CAPTURED; reset enters IDLE.
REQ-015 IDLE -> SETTLE and CAPTURED -> SETTLE on any sample change; SETTLE -> SETTLE with counter cleared on any sample change.
REQ-016 SETTLE -> CAPTURED when the sample has been identical for STABLE_CYCLES consecutive cycles; exactly one capture event per stable period.
REQ-017 On capture with exactly one anodo bit low (position i): decode catodo; update digits[i], valid[i], and seen-mask bit i on the same edge.
REQ-018 Decode table (catodo hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-019 On capture of a pattern not in REQ-018: pulse seg_err, clear valid[i], leave digits[i] unchanged, still set seen-mask bit i.
REQ-020 On capture with anodo = 4'hF (blanked): no update, no error, no seen-mask change.
REQ-021 On capture with two or more anodo bits low: pulse anode_err; no other update.
REQ-022 When a capture makes seen-mask 4'hF, frame_strobe SHALL pulse one cycle later and seen-mask SHALL clear in that same cycle; a capture coinciding with the clear sets its bit in the new mask.
REQ-023 Re-capture of an already-seen position before the frame completes SHALL overwrite digits/valid and SHALL NOT re-trigger frame_strobe.
REQ-024 Latency: digits/valid update on the edge ending the STABLE_CYCLES-th identical sample; pin-to-output latency = SYNC_STAGES + STABLE_CYCLES cycles.
REQ-025 seg_err and anode_err SHALL be registered and pulse on the capture edge; they never assert simultaneously.

Reset
REQ-026 Asserting reset low SHALL immediately force digits=16'h0000, valid=4'h0, frame_strobe=0, seg_err=0, anode_err=0, state IDLE, counter 0, seen-mask 0.
REQ-027 Synchronizer and previous-sample flops SHALL reset to anodo=4'hF, catodo=7'h7F (all off).
REQ-028 Reset asserted mid-SETTLE SHALL discard the pending capture; no pulse SHALL occur on release.
REQ-029 Reset release SHALL be synchronized to clk before the FSM leaves IDLE.

Verification (STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-030 anodo=4'b1110, catodo=7'h30 held 10 cycles -> digits[3:0]=3, valid=4'b0001 exactly 6 cycles after pin change; no error pulses.
REQ-031 Scan 4'b1110/7'h40, 4'b1101/7'h79, 4'b1011/7'h24, 4'b0111/7'h30, 8 cycles each -> digits=16'h3210, valid=4'hF, single frame_strobe one cycle after last capture.
REQ-032 anodo=4'b1101, catodo=7'h7F held -> seg_err one-cycle pulse, valid[1]=0, digits[7:4] unchanged.
REQ-033 anodo=4'b1100 held 8 cycles -> one anode_err pulse; digits, valid, seen-mask unchanged.
REQ-034 catodo toggles 7'h79/7'h24 every 3 cycles for 30 cycles -> no capture, no pulses.
REQ-035 reset low after 2 stable cycles of 4'b1110/7'h00, released while inputs held -> outputs 0 during reset; capture of 8 after resynchronization and STABLE_CYCLES; no spurious pulse.
